// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 byte decoder with held-key tracking, ASCII map and 7-seg display
module ps2_key_decoder #(
   parameter int unsigned CNT_W       = 8,
   parameter bit          SEG_ACT_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_err,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_down,
   output logic [7:0]       key_ascii,
   output logic             key_press,
   output logic [CNT_W-1:0] press_cnt,
   output logic [7:0]       seg0,
   output logic [7:0]       seg1,
   output logic [7:0]       seg2,
   output logic [7:0]       seg3,
   output logic [7:0]       seg4,
   output logic [7:0]       seg5
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   localparam logic [7:0] SEG_BLANK = {8{SEG_ACT_LOW}};

   state_t           state, state_nxt;
   logic             ev_make, ev_brk, ev_ext;
   logic             held_match;
   logic [7:0]       code_nxt, ascii_nxt;
   logic             ext_nxt, down_nxt, press_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [7:0]       cnt_lo;

   // Set-2 scancode to ASCII: uppercase letters, top-row digits, space
   function automatic logic [7:0] ascii_of(input logic [7:0] code);
      case (code)
         8'h1C: ascii_of = 8'h41; 8'h32: ascii_of = 8'h42; 8'h21: ascii_of = 8'h43;
         8'h23: ascii_of = 8'h44; 8'h24: ascii_of = 8'h45; 8'h2B: ascii_of = 8'h46;
         8'h34: ascii_of = 8'h47; 8'h33: ascii_of = 8'h48; 8'h43: ascii_of = 8'h49;
         8'h3B: ascii_of = 8'h4A; 8'h42: ascii_of = 8'h4B; 8'h4B: ascii_of = 8'h4C;
         8'h3A: ascii_of = 8'h4D; 8'h31: ascii_of = 8'h4E; 8'h44: ascii_of = 8'h4F;
         8'h4D: ascii_of = 8'h50; 8'h15: ascii_of = 8'h51; 8'h2D: ascii_of = 8'h52;
         8'h1B: ascii_of = 8'h53; 8'h2C: ascii_of = 8'h54; 8'h3C: ascii_of = 8'h55;
         8'h2A: ascii_of = 8'h56; 8'h1D: ascii_of = 8'h57; 8'h22: ascii_of = 8'h58;
         8'h35: ascii_of = 8'h59; 8'h1A: ascii_of = 8'h5A;
         8'h45: ascii_of = 8'h30; 8'h16: ascii_of = 8'h31; 8'h1E: ascii_of = 8'h32;
         8'h26: ascii_of = 8'h33; 8'h25: ascii_of = 8'h34; 8'h2E: ascii_of = 8'h35;
         8'h36: ascii_of = 8'h36; 8'h3D: ascii_of = 8'h37; 8'h3E: ascii_of = 8'h38;
         8'h46: ascii_of = 8'h39;
         8'h29: ascii_of = 8'h20;
         default: ascii_of = 8'h00;
      endcase
   endfunction

   // Hex glyph in active-high {dp,g..a} form, then polarity applied; dp stays off
   function automatic logic [7:0] seg_hex(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
         4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
         4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
         4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
      endcase
      seg_hex = {1'b0, g} ^ SEG_BLANK;
   endfunction

   // Prefix parser: classifies each accepted byte into make/break events
   always_comb begin
      state_nxt = state;
      ev_make   = 1'b0;
      ev_brk    = 1'b0;
      ev_ext    = 1'b0;
      if (in_valid) begin
         if (in_err) begin
            state_nxt = ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (in_data == 8'hE0)      state_nxt = ST_EXT;
                  else if (in_data == 8'hF0) state_nxt = ST_BRK;
                  else if (in_data == 8'hAA || in_data == 8'hFA || in_data == 8'hEE ||
                           in_data == 8'hFE || in_data == 8'h00 || in_data == 8'hFF)
                     state_nxt = ST_IDLE;
                  else
                     ev_make = 1'b1;
               end
               ST_EXT: begin
                  if (in_data == 8'hF0)      state_nxt = ST_EXT_BRK;
                  else if (in_data == 8'hE0) state_nxt = ST_EXT;
                  else begin
                     ev_make   = 1'b1;
                     ev_ext    = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end
               ST_BRK: begin
                  state_nxt = ST_IDLE;
                  if (in_data != 8'hE0 && in_data != 8'hF0) ev_brk = 1'b1;
               end
               default: begin
                  state_nxt = ST_IDLE;
                  if (in_data != 8'hE0 && in_data != 8'hF0) begin
                     ev_brk = 1'b1;
                     ev_ext = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Held-key update: typematic repeats and foreign breaks leave state untouched
   always_comb begin
      held_match = key_down && (ev_ext == key_ext) && (in_data == key_code);
      code_nxt   = key_code;
      ext_nxt    = key_ext;
      ascii_nxt  = key_ascii;
      down_nxt   = key_down;
      press_nxt  = 1'b0;
      cnt_nxt    = press_cnt;
      if (ev_make && !held_match) begin
         code_nxt  = in_data;
         ext_nxt   = ev_ext;
         ascii_nxt = ev_ext ? 8'h00 : ascii_of(in_data);
         down_nxt  = 1'b1;
         press_nxt = 1'b1;
         cnt_nxt   = press_cnt + CNT_W'(1);
      end
      if (ev_brk && held_match) down_nxt = 1'b0;
      cnt_lo = 8'(cnt_nxt);
   end

   // State, key registers and display digits all load from the same next values
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         key_code  <= 8'h00;
         key_ext   <= 1'b0;
         key_down  <= 1'b0;
         key_ascii <= 8'h00;
         key_press <= 1'b0;
         press_cnt <= '0;
         seg0      <= SEG_BLANK;
         seg1      <= SEG_BLANK;
         seg2      <= SEG_BLANK;
         seg3      <= SEG_BLANK;
         seg4      <= seg_hex(4'h0);
         seg5      <= seg_hex(4'h0);
      end else begin
         state     <= state_nxt;
         key_code  <= code_nxt;
         key_ext   <= ext_nxt;
         key_down  <= down_nxt;
         key_ascii <= ascii_nxt;
         key_press <= press_nxt;
         press_cnt <= cnt_nxt;
         seg0      <= down_nxt ? seg_hex(code_nxt[3:0])  : SEG_BLANK;
         seg1      <= down_nxt ? seg_hex(code_nxt[7:4])  : SEG_BLANK;
         seg2      <= down_nxt ? seg_hex(ascii_nxt[3:0]) : SEG_BLANK;
         seg3      <= down_nxt ? seg_hex(ascii_nxt[7:4]) : SEG_BLANK;
         seg4      <= seg_hex(cnt_lo[3:0]);
         seg5      <= seg_hex(cnt_lo[7:4]);
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder against a prefix-list reference model
module tb_ps2_key_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_err;
   logic [7:0] key_code, key_ascii, press_cnt;
   logic       key_ext, key_down, key_press;
   logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0]      code;
      logic            ext;
      logic            down;
      logic [7:0]      ascii;
      logic            press;
      logic [7:0]      cnt;
      logic [5:0][7:0] seg;
   } exp_t;

   exp_t exp_q[$];

   // reference model state
   logic [7:0] m_code, m_ascii, m_cnt;
   logic       m_ext, m_down, m_press;
   logic [7:0] pending[$];

   ps2_key_decoder #(.CNT_W(8), .SEG_ACT_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_err(in_err),
      .key_code(key_code), .key_ext(key_ext), .key_down(key_down), .key_ascii(key_ascii),
      .key_press(key_press), .press_cnt(press_cnt),
      .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] glyph(input logic [3:0] n);
      string s [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
      logic [7:0] on = 8'h00;
      for (int i = 0; i < s[n].len(); i++) on[s[n][i] - "a"] = 1'b1;
      return ~on;
   endfunction

   function automatic logic [7:0] ascii_model(input logic [7:0] c);
      logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'd65 + 8'(i);
      for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'd48 + 8'(i);
      if (c == 8'h29) return 8'h20;
      return 8'h00;
   endfunction

   function automatic exp_t snap();
      exp_t e;
      e.code  = m_code;  e.ext = m_ext;  e.down = m_down;
      e.ascii = m_ascii; e.press = m_press; e.cnt = m_cnt;
      e.seg[0] = m_down ? glyph(m_code[3:0])  : 8'hFF;
      e.seg[1] = m_down ? glyph(m_code[7:4])  : 8'hFF;
      e.seg[2] = m_down ? glyph(m_ascii[3:0]) : 8'hFF;
      e.seg[3] = m_down ? glyph(m_ascii[7:4]) : 8'hFF;
      e.seg[4] = glyph(m_cnt[3:0]);
      e.seg[5] = glyph(m_cnt[7:4]);
      return e;
   endfunction

   task automatic model_reset();
      m_code = 0; m_ext = 0; m_down = 0; m_ascii = 0; m_press = 0; m_cnt = 0;
      pending.delete();
   endtask

   task automatic model_byte(input logic [7:0] b, input logic err);
      bit has_e0 = 0, has_f0 = 0;
      m_press = 0;
      foreach (pending[i]) begin
         if (pending[i] == 8'hE0) has_e0 = 1;
         if (pending[i] == 8'hF0) has_f0 = 1;
      end
      if (err) begin
         pending.delete();
      end else if (b == 8'hE0) begin
         pending.delete();
         if (!has_f0) pending.push_back(8'hE0);
      end else if (b == 8'hF0) begin
         if (has_f0) pending.delete();
         else pending.push_back(8'hF0);
      end else begin
         pending.delete();
         if (!has_e0 && !has_f0 && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
         end else if (!has_f0) begin
            if (!(m_down && m_code == b && m_ext == has_e0)) begin
               m_code = b; m_ext = has_e0; m_down = 1; m_press = 1;
               m_ascii = has_e0 ? 8'h00 : ascii_model(b);
               m_cnt = m_cnt + 8'd1;
            end
         end else if (m_down && m_code == b && m_ext == has_e0) begin
            m_down = 0;
         end
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
      end
   endtask

   task automatic compare_all(input exp_t e);
      check("key_code", key_code, e.code);
      check("key_ext", {7'd0, key_ext}, {7'd0, e.ext});
      check("key_down", {7'd0, key_down}, {7'd0, e.down});
      check("key_ascii", key_ascii, e.ascii);
      check("key_press", {7'd0, key_press}, {7'd0, e.press});
      check("press_cnt", press_cnt, e.cnt);
      check("seg0", seg0, e.seg[0]);
      check("seg1", seg1, e.seg[1]);
      check("seg2", seg2, e.seg[2]);
      check("seg3", seg3, e.seg[3]);
      check("seg4", seg4, e.seg[4]);
      check("seg5", seg5, e.seg[5]);
   endtask

   task automatic send(input logic [7:0] b, input logic err = 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_data = b; in_err = err;
      model_byte(b, err);
      exp_q.push_back(snap());
   endtask

   task automatic drain();
      @(negedge clk); in_valid = 1'b0; in_err = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      drain();
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all(snap());
      rst = 1'b1;
      @(negedge clk);
   endtask

   // monitor: every accepted byte must produce the queued expected outputs next cycle
   initial begin
      logic v;
      forever begin
         @(posedge clk);
         v = in_valid;
         #1;
         if (v) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL scoreboard_empty: output seen with no expected entry at %0t", $time);
            end else begin
               compare_all(exp_q.pop_front());
            end
         end else begin
            check("idle_press", {7'd0, key_press}, 8'h00);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h29, 8'h45, 8'h16, 8'h75, 8'hAA, 8'h00};
      logic [7:0] b;
      int k;
      rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_err = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all(snap());
      rst = 1'b1;

      // make then break of A
      send(8'h1C); send(8'hF0); send(8'h1C);
      drain();
      check("t1_cnt", press_cnt, 8'd1);
      check("t1_down", {7'd0, key_down}, 8'h00);
      check("t1_seg0_blank", seg0, 8'hFF);

      // typematic repeat
      repeat (5) send(8'h1C);
      drain();
      check("t2_cnt", press_cnt, 8'd2);

      // extended key: plain break ignored, extended break clears
      send(8'hE0); send(8'h75); send(8'hF0); send(8'h75);
      drain();
      check("t3_down_held", {7'd0, key_down}, 8'h01);
      send(8'hE0); send(8'hF0); send(8'h75);
      drain();
      check("t3_ext", {7'd0, key_ext}, 8'h01);
      check("t3_down_clear", {7'd0, key_down}, 8'h00);

      // error byte drops pending E0
      send(8'hE0); send(8'h55, 1'b1); send(8'h1C);
      drain();
      check("t5_ext", {7'd0, key_ext}, 8'h00);

      // reset after F0, then AA is no event and 1C is a press
      send(8'hF0);
      do_reset();
      send(8'hAA); send(8'h1C);
      drain();
      check("t6_cnt", press_cnt, 8'd1);

      // counter wrap
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send(8'h16); send(8'hF0); send(8'h16);
      end
      drain();
      check("t4_cnt_wrap", press_cnt, 8'h00);
      check("t4_seg4", seg4, 8'hC0);

      // random byte streams
      for (int i = 0; i < 600; i++) begin
         k = $urandom_range(0, 10);
         b = (k == 10) ? 8'($urandom) : pool[k];
         send(b, ($urandom_range(0, 19) == 0));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk); in_valid = 1'b0; in_err = 1'b0;
         end
      end
      drain();
      check("queue_drained", 8'(exp_q.size()), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
